// File: rtl/greenhouse_pkg.sv
// Shared types and width constants for the greenhouse HVAC sequencer.
package greenhouse_pkg;

  localparam int TEMP_W   = 8;
  localparam int DIFF_W   = 9;
  localparam int SEXT_PAD = DIFF_W - TEMP_W;
  localparam int STATE_W  = 2;
  localparam int CNT_W    = 8;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE    = 2'd0,
    S_HEAT    = 2'd1,
    S_COOL    = 2'd2,
    S_LOCKOUT = 2'd3
  } state_t;

  function automatic logic signed [DIFF_W-1:0] sext9(input logic [TEMP_W-1:0] v);
    return signed'({{SEXT_PAD{v[TEMP_W-1]}}, v});
  endfunction

endpackage

// File: rtl/greenhouse_hvac_sequencer_if.sv
// Sensor/actuator bundle between the temperature path and the HVAC sequencer.
interface greenhouse_hvac_sequencer_if;
  import greenhouse_pkg::*;

  logic              enable;
  logic              sample_valid;
  logic [TEMP_W-1:0] greenhouse_temp;
  logic [TEMP_W-1:0] setpoint;
  logic              heater_on;
  logic              fan_on;
  logic [STATE_W-1:0] state_o;
  logic              fault;

  modport master (
    output enable, sample_valid, greenhouse_temp, setpoint,
    input  heater_on, fan_on, state_o, fault
  );

  modport slave (
    input  enable, sample_valid, greenhouse_temp, setpoint,
    output heater_on, fan_on, state_o, fault
  );
endinterface

// File: rtl/hvac_dwell_timer.sv
// 8-bit up-counter that saturates at 255; synchronous clear has priority over counting.
module hvac_dwell_timer
  import greenhouse_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr)
      count <= '0;
    else if (count != {CNT_W{1'b1}})
      count <= count + 1'b1;
  end

endmodule

// File: rtl/greenhouse_hvac_sequencer.sv
// Heater/fan sequencer with hysteresis, minimum-on dwell and inter-mode lockout.
// Optional sensor watchdog enabled by defining SENSOR_WDOG_EN.
//
// state   | meaning
// IDLE    | both actuators off, waiting for a sample outside the band
// HEAT    | heater on, held for at least MIN_ON cycles
// COOL    | fan on, held for at least MIN_ON cycles
// LOCKOUT | both off for LOCKOUT cycles after any active mode
module greenhouse_hvac_sequencer
  import greenhouse_pkg::*;
#(
  parameter int HYST    = 2,
  parameter int MIN_ON  = 8,
  parameter int LOCKOUT = 4
`ifdef SENSOR_WDOG_EN
  , parameter int WDOG_CYCLES = 64
`endif
) (
  input logic clk,
  input logic rst,
  greenhouse_hvac_sequencer_if.slave bus
);

  localparam logic signed [DIFF_W-1:0] HYST_P = DIFF_W'(HYST);
  localparam logic signed [DIFF_W-1:0] HYST_N = DIFF_W'(-HYST);
  localparam logic signed [DIFF_W-1:0] ZERO   = '0;
  localparam logic [CNT_W-1:0] MIN_ON_LAST    = CNT_W'(MIN_ON - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST      = CNT_W'(LOCKOUT - 1);

  state_t state_q, state_next;
  logic signed [DIFF_W-1:0] diff_new, diff_q, ed;
  logic [CNT_W-1:0] dwell;
  logic fault_q;

  // 9-bit difference cannot wrap for any pair of 8-bit signed inputs
  assign diff_new = sext9(bus.greenhouse_temp) - sext9(bus.setpoint);
  assign ed       = bus.sample_valid ? diff_new : diff_q;

  always_ff @(posedge clk) begin
    if (rst)
      diff_q <= '0;
    else if (bus.sample_valid)
      diff_q <= diff_new;
  end

  hvac_dwell_timer u_dwell (
    .clk   (clk),
    .rst   (rst),
    .clr   (state_next != state_q),
    .count (dwell)
  );

`ifdef SENSOR_WDOG_EN
  logic [CNT_W-1:0] stale;

  hvac_dwell_timer u_stale (
    .clk   (clk),
    .rst   (rst),
    .clr   (bus.sample_valid),
    .count (stale)
  );

  always_ff @(posedge clk) begin
    if (rst)
      fault_q <= 1'b0;
    else if (stale >= CNT_W'(WDOG_CYCLES))
      fault_q <= 1'b1;
  end
`else
  assign fault_q = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst)
      state_q <= S_IDLE;
    else
      state_q <= state_next;
  end

  always_comb begin
    state_next = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.enable && bus.sample_valid && !fault_q) begin
          if (ed < HYST_N)
            state_next = S_HEAT;
          else if (ed > HYST_P)
            state_next = S_COOL;
        end
      end
      // loss of enable or a stale sensor cuts the dwell short
      S_HEAT: begin
        if (!bus.enable || fault_q)
          state_next = S_LOCKOUT;
        else if (dwell >= MIN_ON_LAST && ed >= ZERO)
          state_next = S_LOCKOUT;
      end
      S_COOL: begin
        if (!bus.enable || fault_q)
          state_next = S_LOCKOUT;
        else if (dwell >= MIN_ON_LAST && ed <= ZERO)
          state_next = S_LOCKOUT;
      end
      S_LOCKOUT: begin
        if (dwell == LOCK_LAST)
          state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign bus.heater_on = (state_q == S_HEAT);
  assign bus.fan_on    = (state_q == S_COOL);
  assign bus.state_o   = state_q;
  assign bus.fault     = fault_q;

endmodule

// File: tb/tb_greenhouse_hvac_sequencer.sv
// Directed bench for greenhouse_hvac_sequencer; watchdog steps run only with SENSOR_WDOG_EN.
module tb_greenhouse_hvac_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad   = 0;

  greenhouse_hvac_sequencer_if bus ();

  greenhouse_hvac_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp(input int temp, input int sp);
    bus.sample_valid    = 1'b1;
    bus.greenhouse_temp = 8'(temp);
    bus.setpoint        = 8'(sp);
    tick();
    bus.sample_valid    = 1'b0;
  endtask

  task automatic chk_state(input string tag, input int st);
    chk(tag, int'(bus.state_o), st);
    chk({tag, "_heat"}, int'(bus.heater_on), (st == 1) ? 1 : 0);
    chk({tag, "_fan"},  int'(bus.fan_on),    (st == 2) ? 1 : 0);
  endtask

  // heater and fan must never be on together
  always @(negedge clk) begin
    total++;
    assert (!(bus.heater_on === 1'b1 && bus.fan_on === 1'b1)) else begin
      bad++;
      $error("FAIL both_on observed=1 expected=0");
    end
  end

  initial begin
    bus.enable          = 1'b0;
    bus.sample_valid    = 1'b0;
    bus.greenhouse_temp = 8'd30;
    bus.setpoint        = 8'd20;
    rst = 1'b1;
    tick();
    tick();
    chk_state("reset", 0);
    chk("reset_fault", int'(bus.fault), 0);
    rst = 1'b0;
    bus.enable = 1'b1;

    // heating cycle: -3 enters HEAT, later +1 exits after MIN_ON
    samp(17, 20);
    chk_state("heat_enter", 1);
    tick();
    tick();
    samp(21, 20);
    repeat (4) tick();
    chk_state("heat_dwell7", 1);
    tick();
    chk_state("heat_exit_lock", 3);
    repeat (3) tick();
    chk_state("heat_lock_d3", 3);
    tick();
    chk_state("heat_lock_idle", 0);

    // hysteresis band edge then cooling
    samp(22, 20);
    chk_state("band_plus2", 0);
    samp(23, 20);
    chk_state("cool_enter", 2);

    // mode reversal via lockout
    repeat (7) tick();
    chk_state("cool_dwell7", 2);
    samp(10, 20);
    chk_state("rev_lock", 3);
    repeat (3) tick();
    chk_state("rev_lock_d3", 3);
    tick();
    chk_state("rev_idle", 0);
    tick();
    chk_state("rev_no_sample", 0);
    samp(10, 20);
    chk_state("rev_heat", 1);

    // enable drop at dwell 3 overrides MIN_ON
    tick();
    tick();
    tick();
    chk_state("en_dwell3", 1);
    bus.enable = 1'b0;
    tick();
    chk_state("en_drop_lock", 3);
    repeat (3) tick();
    tick();
    chk_state("en_lock_idle", 0);
    samp(10, 20);
    chk_state("en_off_idle", 0);
    bus.enable = 1'b1;

    // lower band edge
    samp(18, 20);
    chk_state("band_minus2", 0);

    // extremes: no wrap in the difference
    samp(-128, 127);
    chk_state("ext_heat", 1);
    rst = 1'b1;
    tick();
    chk_state("rst_mid_heat", 0);
    rst = 1'b0;
    tick();
    chk_state("rst_no_lock", 0);
    samp(127, -128);
    chk_state("ext_cool", 2);

`ifdef SENSOR_WDOG_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    begin
      int n;
      n = 0;
      while (bus.fault !== 1'b1 && n < 200) begin
        tick();
        n++;
      end
      chk("wdog_timeout_bound", (n < 200) ? 1 : 0, 1);
      chk("wdog_cycles", n, 65);
    end
    samp(10, 20);
    chk("wdog_sticky", int'(bus.fault), 1);
    chk_state("wdog_idle", 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("wdog_rst_clear", int'(bus.fault), 0);
`else
    repeat (80) tick();
    chk("no_wdog_fault", int'(bus.fault), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
